// File: rtl/comp_flag_pipe.sv
// Two-stage pipelined compensation-flag generator for the approximate divider.
// Stage 1 locates the leading one; stage 2 compares the low residue against the half-step threshold.
module comp_flag_pipe #(
  parameter int WIDTH   = 8,
  parameter int MIN_MSB = 5,
  parameter int GUARD   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_msb,
  output logic                     out_flag,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         flag_cnt
);
  localparam int KW = $clog2(WIDTH);

  logic             r_v1;
  logic             r_mode1;
  logic [WIDTH-1:0] r_data1;
  logic [KW-1:0]    r_k1;
  logic             r_v2;
  logic             r_flag2;
  logic [WIDTH-1:0] r_data2;
  logic [KW-1:0]    r_k2;
  logic [CNT_W-1:0] r_cnt;

  logic             w_en1;
  logic             w_en2;
  logic [KW-1:0]    w_kIn;
  logic [KW-1:0]    w_m;
  logic [WIDTH-1:0] w_one;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_half;
  logic             w_flag;
  logic             w_outXfer;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_en2     = !r_v2 || out_ready;
  assign w_en1     = !r_v1 || w_en2;
  assign in_ready  = w_en1;
  assign w_outXfer = r_v2 && out_ready;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_kIn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) w_kIn = KW'(i);
    end
  end

  assign w_one  = WIDTH'(1);
  assign w_m    = r_k1 - KW'(GUARD);
  assign w_mask = (w_one << w_m) - w_one;
  assign w_res  = r_data1 & w_mask;
  assign w_half = w_one << (w_m - KW'(1));

  always_comb begin
    w_flag = 1'b0;
    if (r_data1 != '0 && int'(r_k1) >= MIN_MSB) begin
      w_flag = r_mode1 ? (w_res >= w_half) : (w_res > w_half);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_data1 <= '0;
      r_k1    <= '0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_mode1 <= in_mode;
        r_data1 <= in_data;
        r_k1    <= w_kIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_flag2 <= 1'b0;
      r_data2 <= '0;
      r_k2    <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_flag2 <= w_flag;
        r_data2 <= r_data1;
        r_k2    <= r_k1;
      end
    end
  end

  // Clear beats a same-cycle count; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_outXfer && r_flag2 && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_v2;
  assign out_data  = r_data2;
  assign out_msb   = r_k2;
  assign out_flag  = r_flag2;
  assign flag_cnt  = r_cnt;

endmodule

// File: tb/tb_comp_flag_pipe.sv
// Self-checking bench for comp_flag_pipe: directed legacy patterns, randomized traffic
// against a behavioural model, counter saturation on a narrow-counter instance, and reset.
module tb_comp_flag_pipe;
  localparam int MIN_MSB = 5;
  localparam int GUARD   = 3;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] k;
    logic       f;
  } expT;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [7:0]  inData;
  logic        inMode;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outData;
  logic [2:0]  outMsb;
  logic        outFlag;
  logic        cntClr;
  logic [15:0] flagCnt;

  logic        c4InValid;
  logic        c4InReady;
  logic [7:0]  c4InData;
  logic        c4InMode;
  logic        c4OutValid;
  logic        c4OutReady;
  logic [7:0]  c4OutData;
  logic [2:0]  c4OutMsb;
  logic        c4OutFlag;
  logic        c4CntClr;
  logic [3:0]  c4FlagCnt;

  int total;
  int bad;

  comp_flag_pipe dut (
    .clk(clk), .rst_n(rstN),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_mode(inMode),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_msb(outMsb),
    .out_flag(outFlag), .cnt_clr(cntClr), .flag_cnt(flagCnt)
  );

  comp_flag_pipe #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rstN),
    .in_valid(c4InValid), .in_ready(c4InReady), .in_data(c4InData), .in_mode(c4InMode),
    .out_valid(c4OutValid), .out_ready(c4OutReady), .out_data(c4OutData), .out_msb(c4OutMsb),
    .out_flag(c4OutFlag), .cnt_clr(c4CntClr), .flag_cnt(c4FlagCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(log2(d)) by repeated halving; 0 for d==0
  function automatic int modelMsb(int d);
    int k = 0;
    int t = d;
    while (t > 1) begin
      t = t / 2;
      k++;
    end
    return k;
  endfunction

  function automatic bit modelFlag(int d, bit mode);
    int k, m, r, h;
    k = modelMsb(d);
    if (d == 0 || k < MIN_MSB) return 1'b0;
    m = k - GUARD;
    r = d % (1 << m);
    h = (1 << m) / 2;
    return mode ? (r >= h) : (r > h);
  endfunction

  function automatic bit legacyFlag(int d);
    if (d >= 32 && d <= 63)   return (d % 4) == 3;
    if (d >= 64 && d <= 127)  return (d % 8) >= 5;
    if (d >= 128 && d <= 255) return (d % 16) >= 9;
    return 1'b0;
  endfunction

  task automatic test_reset;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b want 0", outValid); end
    total++;
    if (outData !== 8'd0 || outMsb !== 3'd0 || outFlag !== 1'b0)
      begin bad++; $display("[TB] FAIL reset_outputs: got data=%0d msb=%0d flag=%0b want 0,0,0", outData, outMsb, outFlag); end
    total++;
    if (flagCnt !== 16'd0 || c4FlagCnt !== 4'd0)
      begin bad++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", flagCnt, c4FlagCnt); end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    total++;
    if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b want 1", inReady); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    int  dataList[9] = '{35, 34, 31, 69, 68, 137, 136, 255, 0};
    bit  flagList[9] = '{1, 0, 0, 1, 0, 1, 0, 1, 0};
    int  msbList[9]  = '{5, 5, 4, 6, 6, 7, 7, 7, 0};
    int  startCyc[9];
    int  sent = 0;
    int  got = 0;
    outReady = 1'b1;
    inMode   = 1'b0;
    for (int t = 0; t < 30 && got < 9; t++) begin
      if (sent < 9) begin inValid = 1'b1; inData = 8'(dataList[sent]); end
      else inValid = 1'b0;
      @(negedge clk);
      if (outValid && outReady) begin
        total++;
        if (outData !== 8'(dataList[got]))
          begin bad++; $display("[TB] FAIL stream_data[%0d]: got %0d want %0d", got, outData, dataList[got]); end
        total++;
        if (outFlag !== flagList[got])
          begin bad++; $display("[TB] FAIL stream_flag[%0d]: got %0b want %0b", got, outFlag, flagList[got]); end
        total++;
        if (outMsb !== 3'(msbList[got]))
          begin bad++; $display("[TB] FAIL stream_msb[%0d]: got %0d want %0d", got, outMsb, msbList[got]); end
        total++;
        if (t !== startCyc[got] + 2)
          begin bad++; $display("[TB] FAIL stream_latency[%0d]: got %0d want %0d", got, t - startCyc[got], 2); end
        got++;
      end
      if (inValid && inReady) begin startCyc[sent] = t; sent++; end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    total++;
    if (got !== 9) begin bad++; $display("[TB] FAIL stream_count: got %0d want 9", got); end
  endtask

  task automatic test_mode1;
    int dataList[4] = '{34, 68, 136, 67};
    bit flagList[4] = '{1, 1, 1, 0};
    int sent = 0;
    int got = 0;
    outReady = 1'b1;
    inMode   = 1'b1;
    for (int t = 0; t < 20 && got < 4; t++) begin
      if (sent < 4) begin inValid = 1'b1; inData = 8'(dataList[sent]); end
      else inValid = 1'b0;
      @(negedge clk);
      if (outValid && outReady) begin
        total++;
        if (outData !== 8'(dataList[got]) || outFlag !== flagList[got])
          begin bad++; $display("[TB] FAIL mode1[%0d]: got data=%0d flag=%0b want data=%0d flag=%0b", got, outData, outFlag, dataList[got], flagList[got]); end
        got++;
      end
      if (inValid && inReady) sent++;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    inMode  = 1'b0;
    total++;
    if (got !== 4) begin bad++; $display("[TB] FAIL mode1_count: got %0d want 4", got); end
  endtask

  task automatic test_sweep;
    int sent = 0;
    int got = 0;
    int nFlag = 0;
    int errs = 0;
    cntClr = 1'b1;
    @(posedge clk); #1;
    cntClr   = 1'b0;
    outReady = 1'b1;
    inMode   = 1'b0;
    for (int t = 0; t < 300 && got < 256; t++) begin
      if (sent < 256) begin inValid = 1'b1; inData = 8'(sent); end
      else inValid = 1'b0;
      @(negedge clk);
      if (outValid && outReady) begin
        if (outData !== 8'(got) || outFlag !== legacyFlag(got) || outMsb !== 3'(modelMsb(got))) begin
          errs++;
          $display("[TB] FAIL sweep[%0d]: got data=%0d flag=%0b msb=%0d want flag=%0b msb=%0d", got, outData, outFlag, outMsb, legacyFlag(got), modelMsb(got));
        end
        if (legacyFlag(got)) nFlag++;
        got++;
      end
      if (inValid && inReady) sent++;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    total++;
    if (errs !== 0 || got !== 256) begin bad++; $display("[TB] FAIL sweep_summary: got errs=%0d outputs=%0d want 0/256", errs, got); end
    @(negedge clk);
    total++;
    if (flagCnt !== 16'(nFlag)) begin bad++; $display("[TB] FAIL sweep_cnt: got %0d want %0d", flagCnt, nFlag); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    expT q[$];
    expT e;
    bit  prevStall = 1'b0;
    bit  sawDrop = 1'b0;
    logic [7:0] pData;
    logic [2:0] pMsb;
    logic       pFlag;
    int  sent = 0;
    int  got = 0;
    for (int t = 0; t < 40 && got < 5; t++) begin
      outReady = ((t % 3) == 0);
      if (sent < 5) begin
        inValid = 1'b1;
        inData  = 8'($urandom_range(0, 255));
        inMode  = 1'($urandom_range(0, 1));
      end else inValid = 1'b0;
      @(negedge clk);
      total++;
      if (inReady !== !(q.size() == 2 && !outReady))
        begin bad++; $display("[TB] FAIL bp_in_ready: got %0b want %0b", inReady, !(q.size() == 2 && !outReady)); end
      if (!inReady) sawDrop = 1'b1;
      if (prevStall) begin
        total++;
        if (outValid !== 1'b1 || outData !== pData || outFlag !== pFlag || outMsb !== pMsb)
          begin bad++; $display("[TB] FAIL bp_hold: got v=%0b data=%0d flag=%0b want v=1 data=%0d flag=%0b", outValid, outData, outFlag, pData, pFlag); end
      end
      if (outValid && outReady) begin
        total++;
        if (q.size() == 0) begin bad++; $display("[TB] FAIL bp_spurious: got data=%0d want none", outData); end
        else begin
          e = q.pop_front();
          if (outData !== e.d || outFlag !== e.f || outMsb !== e.k)
            begin bad++; $display("[TB] FAIL bp_result: got data=%0d flag=%0b msb=%0d want %0d,%0b,%0d", outData, outFlag, outMsb, e.d, e.f, e.k); end
        end
        got++;
      end
      if (inValid && inReady) begin
        e.d = inData; e.k = 3'(modelMsb(int'(inData))); e.f = modelFlag(int'(inData), inMode);
        q.push_back(e);
        sent++;
      end
      prevStall = outValid && !outReady;
      pData = outData; pFlag = outFlag; pMsb = outMsb;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    total++;
    if (got !== 5 || q.size() !== 0) begin bad++; $display("[TB] FAIL bp_count: got %0d left %0d want 5 left 0", got, q.size()); end
    total++;
    if (sawDrop !== 1'b1) begin bad++; $display("[TB] FAIL bp_in_ready_drop: got %0b want 1", sawDrop); end
  endtask

  task automatic test_back_to_back;
    expT q[$];
    expT e;
    bit  prevStall = 1'b0;
    logic [7:0] pData;
    logic [2:0] pMsb;
    logic       pFlag;
    for (int t = 0; t < 200; t++) begin
      if (t < 170) begin
        inValid  = ($urandom_range(0, 3) != 0);
        inData   = 8'($urandom_range(0, 255));
        inMode   = 1'($urandom_range(0, 1));
        outReady = ($urandom_range(0, 3) != 0);
      end else begin
        inValid  = 1'b0;
        outReady = 1'b1;
      end
      @(negedge clk);
      total++;
      if (inReady !== !(q.size() == 2 && !outReady))
        begin bad++; $display("[TB] FAIL b2b_in_ready: got %0b want %0b", inReady, !(q.size() == 2 && !outReady)); end
      if (prevStall) begin
        total++;
        if (outValid !== 1'b1 || outData !== pData || outFlag !== pFlag || outMsb !== pMsb)
          begin bad++; $display("[TB] FAIL b2b_hold: got data=%0d flag=%0b want data=%0d flag=%0b", outData, outFlag, pData, pFlag); end
      end
      if (outValid && outReady) begin
        total++;
        if (q.size() == 0) begin bad++; $display("[TB] FAIL b2b_spurious: got data=%0d want none", outData); end
        else begin
          e = q.pop_front();
          if (outData !== e.d || outFlag !== e.f || outMsb !== e.k)
            begin bad++; $display("[TB] FAIL b2b_result: got data=%0d flag=%0b msb=%0d want %0d,%0b,%0d", outData, outFlag, outMsb, e.d, e.f, e.k); end
        end
      end
      if (inValid && inReady) begin
        e.d = inData; e.k = 3'(modelMsb(int'(inData))); e.f = modelFlag(int'(inData), inMode);
        q.push_back(e);
      end
      prevStall = outValid && !outReady;
      pData = outData; pFlag = outFlag; pMsb = outMsb;
      @(posedge clk); #1;
    end
    total++;
    if (q.size() !== 0) begin bad++; $display("[TB] FAIL b2b_leftover: got %0d want 0", q.size()); end
  endtask

  task automatic test_counter_sat;
    int sent = 0;
    int got = 0;
    bit seen = 1'b0;
    c4OutReady = 1'b1;
    c4InMode   = 1'b0;
    c4InData   = 8'd255;
    for (int t = 0; t < 60 && got < 20; t++) begin
      c4InValid = (sent < 20);
      @(negedge clk);
      if (c4OutValid && c4OutReady) begin
        total++;
        if (c4FlagCnt !== 4'((got < 15) ? got : 15))
          begin bad++; $display("[TB] FAIL sat_cnt[%0d]: got %0d want %0d", got, c4FlagCnt, (got < 15) ? got : 15); end
        got++;
      end
      if (c4InValid && c4InReady) sent++;
      @(posedge clk); #1;
    end
    c4InValid = 1'b0;
    @(negedge clk);
    total++;
    if (c4FlagCnt !== 4'd15) begin bad++; $display("[TB] FAIL sat_final: got %0d want 15", c4FlagCnt); end
    @(posedge clk); #1;
    c4InValid = 1'b1;
    @(posedge clk); #1;
    c4InValid = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      if (c4OutValid) begin
        c4CntClr = 1'b1;
        seen = 1'b1;
      end
      @(posedge clk); #1;
      c4CntClr = 1'b0;
    end
    @(negedge clk);
    total++;
    if (seen !== 1'b1 || c4FlagCnt !== 4'd0)
      begin bad++; $display("[TB] FAIL clr_priority: got seen=%0b cnt=%0d want 1/0", seen, c4FlagCnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    int startT = -1;
    bit gotFresh = 1'b0;
    outReady = 1'b0;
    inValid  = 1'b1;
    inMode   = 1'b0;
    for (int t = 0; t < 6; t++) begin
      inData = 8'($urandom_range(1, 255));
      @(negedge clk);
      if (!inReady) break;
      @(posedge clk); #1;
    end
    total++;
    if (outValid !== 1'b1 || inReady !== 1'b0)
      begin bad++; $display("[TB] FAIL mid_full: got v=%0b rdy=%0b want 1/0", outValid, inReady); end
    @(posedge clk); #1;
    rstN    = 1'b0;
    inValid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    total++;
    if (outValid !== 1'b0 || flagCnt !== 16'd0)
      begin bad++; $display("[TB] FAIL mid_reset: got v=%0b cnt=%0d want 0/0", outValid, flagCnt); end
    outReady = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      total++;
      if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale[%0d]: got v=%0b data=%0d want v=0", t, outValid, outData); end
      @(posedge clk); #1;
    end
    for (int t = 0; t < 8 && !gotFresh; t++) begin
      inValid = (startT < 0);
      inData  = 8'd35;
      @(negedge clk);
      if (outValid) begin
        total++;
        if (outData !== 8'd35 || outFlag !== 1'b1 || outMsb !== 3'd5 || t !== startT + 2)
          begin bad++; $display("[TB] FAIL mid_fresh: got data=%0d flag=%0b msb=%0d lat=%0d want 35,1,5,2", outData, outFlag, outMsb, t - startT); end
        gotFresh = 1'b1;
      end
      if (inValid && inReady) startT = t;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    total++;
    if (gotFresh !== 1'b1) begin bad++; $display("[TB] FAIL mid_fresh_timeout: got %0b want 1", gotFresh); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    rstN = 1'b0;
    inValid = 1'b0; inData = 8'd0; inMode = 1'b0; outReady = 1'b1; cntClr = 1'b0;
    c4InValid = 1'b0; c4InData = 8'd0; c4InMode = 1'b0; c4OutReady = 1'b1; c4CntClr = 1'b0;
    test_reset;
    test_stream;
    test_mode1;
    test_sweep;
    test_backpressure;
    test_back_to_back;
    test_counter_sat;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
